// File: rtl/riscv_pkg.sv
// Shared RV32I front-end definitions: datapath width, reset vector,
// canonical NOP and the entry type carried through the fetch buffer.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0]      instr;
        logic [XLEN-1:0]  pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of the fetch stage's memory, redirect and decode handshakes.
// The fetch unit is the master; memory, execute and decode sit on the slave side.
interface fetch_unit_if;

    logic                       imem_req_valid;
    logic                       imem_req_ready;
    logic [riscv_pkg::XLEN-1:0] imem_req_addr;
    logic                       imem_rsp_valid;
    logic [31:0]                imem_rsp_data;

    logic                       redirect_valid;
    logic [riscv_pkg::XLEN-1:0] redirect_pc;

    logic                       dec_valid;
    logic                       dec_ready;
    logic [31:0]                dec_instr;
    logic [riscv_pkg::XLEN-1:0] dec_pc;
    logic [riscv_pkg::XLEN-1:0] dec_pc_plus4;

    modport master (
        output imem_req_valid,
        input  imem_req_ready,
        output imem_req_addr,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        input  redirect_valid,
        input  redirect_pc,
        output dec_valid,
        input  dec_ready,
        output dec_instr,
        output dec_pc,
        output dec_pc_plus4
    );

    modport slave (
        input  imem_req_valid,
        output imem_req_ready,
        input  imem_req_addr,
        output imem_rsp_valid,
        output imem_rsp_data,
        output redirect_valid,
        output redirect_pc,
        input  dec_valid,
        output dec_ready,
        input  dec_instr,
        input  dec_pc,
        input  dec_pc_plus4
    );

endinterface

// File: rtl/fetch_buffer.sv
// Circular instruction FIFO with a registered head. The head registers are
// loaded with whatever entry will be at the front after this cycle's
// push/pop/flush, so decode sees only flop outputs and a push into an empty
// buffer becomes visible one cycle later.
module fetch_buffer
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  fetch_entry_t               push_entry_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       head_valid_o,
    output fetch_entry_t               head_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   remain;
    logic               head_valid_q, head_valid_d;
    fetch_entry_t       head_q, head_d;
    logic               do_pop;
    logic               do_push;

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && !flush_i;

    // Next pointers, occupancy and the entry that will sit at the head.
    always_comb begin
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        head_valid_d = head_valid_q;
        head_d       = head_q;
        remain       = count_q - CNT_W'(do_pop);
        if (flush_i) begin
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
            count_d      = '0;
            head_valid_d = 1'b0;
        end else begin
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            count_d      = remain + CNT_W'(do_push);
            head_valid_d = (count_d != '0);
            if (remain == '0) begin
                if (do_push) begin
                    head_d = push_entry_i;
                end
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end
    end

    // Pointer, count and head registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            head_valid_q <= 1'b0;
            head_q       <= '0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            head_valid_q <= head_valid_d;
            head_q       <= head_d;
        end
    end

    // Storage array; contents are only meaningful under the valid count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_entry_i;
        end
    end

    assign count_o      = count_q;
    assign head_valid_o = head_valid_q;
    assign head_o       = head_q;

    push_into_full_buffer: assert property (
        @(posedge clk) disable iff (rst)
        !(push_i && !flush_i && (count_q == CNT_W'(DEPTH)))
    );

endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch stage: owns the fetch PC, issues in-order requests bounded by
// buffer credits, tags returning words with their PC and discards words that
// belong to a fetch stream abandoned by a redirect.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int              BUF_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    fetch_unit_if.master  bus
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int SUM_W = CNT_W + 1;

    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]  rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0] buf_count;
    logic [XLEN-1:0]  redir_target;
    logic [SUM_W-1:0] credits_used;
    logic             req_valid;
    logic             req_accept;
    logic             rsp_keep;
    logic             dec_pop;
    logic             head_valid;
    fetch_entry_t     push_entry;
    fetch_entry_t     head;

    assign redir_target = bus.redirect_pc & ~XLEN'(3);

    // A slot is reserved for every word already buffered or still in flight,
    // so a kept response can never find the buffer full.
    assign credits_used = SUM_W'(buf_count) + SUM_W'(outstanding_q);
    assign req_valid    = !rst && !bus.redirect_valid
                          && (credits_used < SUM_W'(BUF_DEPTH));
    assign req_accept   = req_valid && bus.imem_req_ready;
    assign rsp_keep     = bus.imem_rsp_valid && !bus.redirect_valid
                          && (drop_cnt_q == '0);
    assign dec_pop      = head_valid && bus.dec_ready;

    assign push_entry.instr = bus.imem_rsp_data;
    assign push_entry.pc    = rsp_pc_q;

    // PC, in-flight and stale-response bookkeeping for the coming cycle.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        drop_cnt_d    = drop_cnt_q;
        outstanding_d = outstanding_q + CNT_W'(req_accept)
                        - CNT_W'(bus.imem_rsp_valid);
        if (bus.redirect_valid) begin
            fetch_pc_d = redir_target;
            rsp_pc_d   = redir_target;
            drop_cnt_d = outstanding_q - CNT_W'(bus.imem_rsp_valid);
        end else begin
            if (req_accept) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            if (rsp_keep) begin
                rsp_pc_d = rsp_pc_q + XLEN'(4);
            end
            if (bus.imem_rsp_valid && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - CNT_W'(1);
            end
        end
    end

    // Fetch-side state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    fetch_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_buffer (
        .clk          (clk),
        .rst          (rst),
        .push_i       (rsp_keep),
        .push_entry_i (push_entry),
        .pop_i        (dec_pop),
        .flush_i      (bus.redirect_valid),
        .count_o      (buf_count),
        .head_valid_o (head_valid),
        .head_o       (head)
    );

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = fetch_pc_q;
    assign bus.dec_valid      = head_valid;
    assign bus.dec_instr      = head.instr;
    assign bus.dec_pc         = head.pc;
    assign bus.dec_pc_plus4   = head.pc + XLEN'(4);

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit. A behavioural model keeps the in-flight
// requests (which double as the instruction memory) and the decode queue as
// plain SV queues and predicts every visible output each cycle.
module tb_fetch_unit;
    import riscv_pkg::*;

    localparam int          DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fetch_unit_if bus ();

    fetch_unit #(
        .RESET_PC  (RST_PC),
        .BUF_DEPTH (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } flight_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    typedef struct {
        int          rstCycles;
        int          cycles;
        int          pReady;
        int          pDec;
        int          pRedir;
        int          maxLat;
        bit          forceRedir;
        logic [31:0] forcePc;
    } phase_t;

    flight_t     flight[$];
    entry_t      fifo[$];
    logic [31:0] mPc;
    int          cycle;
    int          lastDue;
    bit          everReset;
    bit          afterReset;

    int          pReady, pDec, pRedir, maxLat;
    bit          forceRedir;
    logic [31:0] forcePc;

    int checks   = 0;
    int failures = 0;

    function automatic logic [31:0] instrFor(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    // One comparison: count it, report it when it disagrees.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)",
                     tag, actual, expected, cycle);
        end
    endtask

    // Drive this cycle's inputs; memory answers in order when a word is due.
    task automatic applyStimulus(input bit doReset);
        int sel;
        rst                = doReset;
        bus.imem_req_ready = ($urandom_range(99) < pReady);
        bus.dec_ready      = ($urandom_range(99) < pDec);
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = $urandom;
        if (!doReset) begin
            if (forceRedir) begin
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = forcePc;
                forceRedir         = 1'b0;
            end else if ($urandom_range(99) < pRedir) begin
                bus.redirect_valid = 1'b1;
                sel = $urandom_range(3);
                case (sel)
                    0:       bus.redirect_pc = $urandom;
                    1:       bus.redirect_pc = $urandom_range(255);
                    2:       bus.redirect_pc = 32'hFFFF_FFF0 | $urandom_range(15);
                    default: bus.redirect_pc = $urandom & 32'h0000_0FFF;
                endcase
            end
        end
        if (!doReset && flight.size() != 0 && flight[0].due <= cycle) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = instrFor(flight[0].addr);
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = $urandom;
        end
    endtask

    // Compare outputs against the model, then advance the model past the edge.
    task automatic stepCycle(input bit doReset);
        bit          expReqValid;
        bit          pop;
        bit          accept;
        int          d;
        flight_t     f;
        logic [31:0] target;

        @(negedge clk);
        applyStimulus(doReset);
        #1;

        expReqValid = !doReset && !bus.redirect_valid
                      && ((fifo.size() + flight.size()) < DEPTH);
        checkOutput("req_valid", bus.imem_req_valid, expReqValid);
        if (expReqValid) checkOutput("req_addr", bus.imem_req_addr, mPc);
        if (everReset) begin
            checkOutput("dec_valid", bus.dec_valid, (fifo.size() != 0));
            if (fifo.size() != 0) begin
                checkOutput("dec_pc", bus.dec_pc, fifo[0].pc);
                checkOutput("dec_instr", bus.dec_instr, fifo[0].instr);
                checkOutput("dec_pc_plus4", bus.dec_pc_plus4, fifo[0].pc + 32'd4);
            end else if (afterReset) begin
                checkOutput("rst_dec_pc", bus.dec_pc, 32'h0);
                checkOutput("rst_dec_instr", bus.dec_instr, 32'h0);
                checkOutput("rst_dec_pc_plus4", bus.dec_pc_plus4, 32'h4);
            end
        end

        if (doReset) begin
            fifo.delete();
            flight.delete();
            mPc        = RST_PC;
            lastDue    = 0;
            everReset  = 1'b1;
            afterReset = 1'b1;
        end else begin
            pop    = (fifo.size() != 0) && bus.dec_ready;
            accept = expReqValid && bus.imem_req_ready;
            if (pop) void'(fifo.pop_front());
            if (bus.imem_rsp_valid) begin
                f = flight.pop_front();
                if (!f.stale && !bus.redirect_valid) begin
                    fifo.push_back('{pc: f.addr, instr: instrFor(f.addr)});
                    afterReset = 1'b0;
                end
            end
            if (bus.redirect_valid) begin
                target = bus.redirect_pc;
                target[1:0] = 2'b00;
                fifo.delete();
                foreach (flight[i]) flight[i].stale = 1'b1;
                mPc = target;
            end
            if (accept) begin
                d = cycle + int'($urandom_range(maxLat, 1));
                if (d <= lastDue) d = lastDue + 1;
                flight.push_back('{addr: mPc, due: d, stale: 1'b0});
                lastDue = d;
                mPc     = mPc + 32'd4;
            end
        end
        cycle++;
    endtask

    phase_t phases[9];

    initial begin
        rst                = 1'b1;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.dec_ready      = 1'b0;
        cycle      = 0;
        lastDue    = 0;
        mPc        = RST_PC;
        everReset  = 1'b0;
        afterReset = 1'b0;
        forceRedir = 1'b0;
        forcePc    = '0;

        //            rst  cyc  rdy  dec  rdir lat force  pc
        phases[0] = '{2,   30,  100, 100, 0,   1,  1'b0, 32'h0};
        phases[1] = '{0,   12,  100, 0,   0,   1,  1'b0, 32'h0};
        phases[2] = '{0,   20,  100, 100, 0,   1,  1'b0, 32'h0};
        phases[3] = '{0,   40,  100, 100, 0,   3,  1'b1, 32'h0000_0100};
        phases[4] = '{0,   40,  100, 100, 0,   1,  1'b1, 32'h0000_0203};
        phases[5] = '{0,   40,  20,  100, 0,   2,  1'b1, 32'hFFFF_FFF7};
        phases[6] = '{0,   400, 70,  70,  10,  3,  1'b0, 32'h0};
        phases[7] = '{1,   400, 60,  60,  25,  4,  1'b0, 32'h0};
        phases[8] = '{1,   200, 90,  50,  5,   2,  1'b0, 32'h0};

        foreach (phases[p]) begin
            pReady     = phases[p].pReady;
            pDec       = phases[p].pDec;
            pRedir     = phases[p].pRedir;
            maxLat     = phases[p].maxLat;
            for (int r = 0; r < phases[p].rstCycles; r++) stepCycle(1'b1);
            forceRedir = phases[p].forceRedir;
            forcePc    = phases[p].forcePc;
            for (int c = 0; c < phases[p].cycles; c++) stepCycle(1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
